popcount_frame_accumulator: RTL

- Downstream consumer of the 4-input ones-count encoder. Takes one 3-bit count (0-4) per accepted sample.
- Sums the counts over a frame of FRAME_LEN samples.
- Presents the frame total on a valid/ready output port.
- Lets the board report how many input bits were high across a window of samples, instead of a single instant.

---
 rtl/popcount_pkg.sv | 35 +++
 rtl/popcount_frame_accumulator_sample_counter.sv | 43 ++++
 rtl/popcount_frame_accumulator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_pkg
//  Description : Shared constants, state type and sizing helper for the
//                popcount frame accumulator slice.
//                  COUNT_W        - width of one ones-count sample
//                  MAX_COUNT      - largest legal ones-count value
//                  state_t        - ACCUM / HOLD frame states
//                  min_sum_width  - narrowest total width that cannot
//                                   overflow for a given frame length
//  Revision    : 1.0 - initial release
// ============================================================================
package popcount_pkg;

    localparam int COUNT_W   = 3;
    localparam int MAX_COUNT = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Smallest w such that 2^w > MAX_COUNT * frame_len, so a frame of
    // all-legal counts can never wrap.
    function automatic int min_sum_width(input int frame_len);
        for (int w = 1; w < 32; w++) begin
            if ((64'd1 << w) > 64'(MAX_COUNT * frame_len)) begin
                return w;
            end
        end
        return 32;
    endfunction

endpackage : popcount_pkg
`default_nettype wire

// File: rtl/popcount_frame_accumulator_sample_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sample_counter
//  Description : Modulo-FRAME_LEN sample index counter.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                i_enable   - advance the index this cycle
//                o_index    - current sample index (0 .. FRAME_LEN-1)
//                o_terminal - index is at the last sample of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_counter #(
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    output logic [IDX_W-1:0] o_index,
    output logic             o_terminal
);

    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(FRAME_LEN - 1);

    logic [IDX_W-1:0] r_index;

    assign o_index    = r_index;
    assign o_terminal = (r_index == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= '0;
        end else if (i_enable) begin
            if (o_terminal) begin
                r_index <= '0;
            end else begin
                r_index <= r_index + 1'b1;
            end
        end
    end

endmodule : sample_counter
`default_nettype wire

// File: rtl/popcount_frame_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_frame_accumulator
//  Description : Sums FRAME_LEN ones-counts from the encoder stage and
//                presents each frame total on a valid/ready output port.
//  Ports       : clk          - clock, rising edge
//                rst          - asynchronous active-high reset
//                i_in_valid   - i_count is valid this cycle
//                i_count      - ones count (0..4 legal)
//                o_in_ready   - a sample is accepted this cycle if valid
//                o_out_valid  - o_total holds a completed frame sum
//                o_total      - frame sum, stable while o_out_valid
//                i_out_ready  - consumer takes o_total this cycle
//                o_bad_count  - sticky: a count of 5..7 was accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_frame_accumulator
    import popcount_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int SUM_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_in_valid,
    input  logic [COUNT_W-1:0]   i_count,
    output logic                 o_in_ready,
    output logic                 o_out_valid,
    output logic [SUM_WIDTH-1:0] o_total,
    input  logic                 i_out_ready,
    output logic                 o_bad_count
);

    localparam int IDX_W = $clog2(FRAME_LEN);

    generate
        if ((FRAME_LEN < 2) || (FRAME_LEN > 255) ||
            (SUM_WIDTH < min_sum_width(FRAME_LEN))) begin : g_bad_params
            $error("popcount_frame_accumulator: illegal FRAME_LEN/SUM_WIDTH");
        end
    endgenerate

    state_t               r_state;
    state_t               w_next_state;
    logic [SUM_WIDTH-1:0] r_acc;
    logic [SUM_WIDTH-1:0] r_total;
    logic                 r_bad_count;

    logic                 w_accept;
    logic                 w_terminal;
    logic [IDX_W-1:0]     w_index;
    logic [SUM_WIDTH-1:0] w_count_ext;
    logic [SUM_WIDTH-1:0] w_acc_base;
    logic [SUM_WIDTH-1:0] w_sum;

    // Ready depends only on state, so deriving accept from the state
    // directly keeps the handshake free of combinational feedback.
    assign w_accept    = i_in_valid & (r_state == ACCUM);
    assign w_count_ext = {{(SUM_WIDTH - COUNT_W){1'b0}}, i_count};
    // The first sample of every frame starts from zero regardless of
    // whatever the accumulator register holds.
    assign w_acc_base  = (w_index == '0) ? '0 : r_acc;
    assign w_sum       = w_acc_base + w_count_ext;

    assign o_total     = r_total;
    assign o_bad_count = r_bad_count;

    sample_counter #(
        .FRAME_LEN (FRAME_LEN),
        .IDX_W     (IDX_W)
    ) u_sample_counter (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (w_accept),
        .o_index    (w_index),
        .o_terminal (w_terminal)
    );

    always_comb begin
        w_next_state = r_state;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        case (r_state)
            ACCUM: begin
                o_in_ready = 1'b1;
                if (w_accept && w_terminal) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_next_state = ACCUM;
                end
            end
            default: begin
                w_next_state = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_total     <= '0;
            r_bad_count <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                if (w_terminal) begin
                    r_total <= w_sum;
                    r_acc   <= '0;
                end else begin
                    r_acc <= w_sum;
                end
                if (i_count > COUNT_W'(MAX_COUNT)) begin
                    r_bad_count <= 1'b1;
                end
            end
        end
    end

endmodule : popcount_frame_accumulator
`default_nettype wire
